// File: rtl/serial_alu.sv
// serial_alu: multi-cycle ALU. It processes one bit, or one shift step, per clock.
// A one-cycle pulse on inp latches opcode/a/b and starts an operation.
// The operation then runs for N edges in RUN and returns to IDLE.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   inp         start pulse; it also restarts an operation that is in progress
//   opcode      0 ADD, 1 SUB, 2 AND, 3 OR, 4 NOT, 5 SHL, 6 SHR, 7 MUL
//   a, b        N-bit operands
//   y           N-bit result (lower half of the product for MUL)
//   y_ext       upper half of the product for MUL, else 0
//   ovf         carry out for ADD, borrow for SUB, else 0
module serial_alu #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inp,
  input  logic [2:0]   opcode,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] y_ext,
  output logic [N-1:0] y,
  output logic         ovf
);

  localparam int unsigned CW = $clog2(N);
  localparam int unsigned PW = 2 * N;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_NOT = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [N-1:0]    a_r;
  logic [N-1:0]    b_r;
  logic [2:0]      op_r;
  logic            carry;

  // One bit-slice of the ripple adder. SUB adds the complement of b.
  logic            a_bit;
  logic            b_bit;
  logic            sum_c;
  logic            cout_c;
  logic            last_c;
  logic [PW-1:0]   addend_c;
  logic [PW-1:0]   acc_next_c;

  always_comb begin
    a_bit      = a_r[cnt];
    b_bit      = (op_r == OP_SUB) ? ~b_r[cnt] : b_r[cnt];
    sum_c      = a_bit ^ b_bit ^ carry;
    cout_c     = (a_bit & b_bit) | (carry & (a_bit ^ b_bit));
    last_c     = (cnt == CW'(N - 1));
    addend_c   = a_bit ? (PW'(b_r) << cnt) : '0;
    acc_next_c = {y_ext, y} + addend_c;
  end

  // FSM, operand latches and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      a_r   <= '0;
      b_r   <= '0;
      op_r  <= OP_ADD;
      carry <= 1'b0;
      y     <= '0;
      y_ext <= '0;
      ovf   <= 1'b0;
    end else if (inp) begin
      // A start pulse always wins, even in RUN. Nothing is queued.
      state <= RUN;
      cnt   <= '0;
      a_r   <= a;
      b_r   <= b;
      op_r  <= opcode;
      carry <= (opcode == OP_SUB);
      y_ext <= '0;
      ovf   <= 1'b0;
      case (opcode)
        OP_SHL:  y <= a << 1;
        OP_SHR:  y <= a >> 1;
        default: y <= '0;
      endcase
    end else if (state == RUN) begin
      cnt <= cnt + CW'(1);
      if (last_c) begin
        state <= IDLE;
      end
      case (op_r)
        OP_ADD, OP_SUB: begin
          y[cnt] <= sum_c;
          carry  <= cout_c;
          // SUB reports a borrow, which is the inverse of the final carry.
          if (last_c) begin
            ovf <= (op_r == OP_SUB) ? ~cout_c : cout_c;
          end
        end
        OP_AND:  y[cnt] <= a_r[cnt] & b_r[cnt];
        OP_OR:   y[cnt] <= a_r[cnt] | b_r[cnt];
        OP_NOT:  y[cnt] <= ~a_r[cnt];
        OP_SHL:  y <= y << 1;
        OP_SHR:  y <= y >> 1;
        OP_MUL:  {y_ext, y} <= acc_next_c;
        default: y <= y;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_alu.sv
// tb_serial_alu: directed and randomised checks of serial_alu against an arithmetic model.
module tb_serial_alu;

  localparam int unsigned N = 8;

  logic         clk;
  logic         rst_n;
  logic         inp;
  logic [2:0]   opcode;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [N-1:0] y_ext;
  logic [N-1:0] y;
  logic         ovf;

  int n_cmp = 0;
  int n_err = 0;

  serial_alu #(.N(N)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .inp    (inp),
    .opcode (opcode),
    .a      (a),
    .b      (b),
    .y_ext  (y_ext),
    .y      (y),
    .ovf    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Result after the start edge plus N RUN edges, written as plain arithmetic.
  task automatic model(input logic [2:0] op, input int unsigned av, input int unsigned bv,
                       output int unsigned ey, output int unsigned ex, output int unsigned eo);
    int unsigned m;
    m  = (1 << N) - 1;
    ey = 0;
    ex = 0;
    eo = 0;
    case (op)
      3'd0: begin ey = (av + bv) & m; eo = (av + bv) >> N; end
      3'd1: begin ey = (av - bv) & m; eo = (av < bv) ? 1 : 0; end
      3'd2: ey = av & bv;
      3'd3: ey = av | bv;
      3'd4: ey = ~av & m;
      3'd5: ey = (av << (N + 1)) & m;
      3'd6: ey = av >> (N + 1);
      default: begin ey = (av * bv) & m; ex = (av * bv) >> N; end
    endcase
  endtask

  // Drive a start pulse at a falling edge. The pulse is sampled by the next rising edge.
  task automatic start(input logic [2:0] op, input logic [N-1:0] av, input logic [N-1:0] bv);
    @(negedge clk);
    opcode = op;
    a      = av;
    b      = bv;
    inp    = 1'b1;
    @(negedge clk);
    inp    = 1'b0;
    // Operand changes during RUN must be ignored.
    opcode = 3'($urandom);
    a      = N'($urandom);
    b      = N'($urandom);
  endtask

  task automatic finish_and_check(input string tag, input logic [2:0] op,
                                  input logic [N-1:0] av, input logic [N-1:0] bv);
    int unsigned ey, ex, eo;
    repeat (N) @(negedge clk);
    model(op, av, bv, ey, ex, eo);
    chk({tag, ".y"}, 32'(y), 32'(ey));
    chk({tag, ".y_ext"}, 32'(y_ext), 32'(ex));
    chk({tag, ".ovf"}, 32'(ovf), 32'(eo));
  endtask

  task automatic run_op(input string tag, input logic [2:0] op,
                        input logic [N-1:0] av, input logic [N-1:0] bv);
    start(op, av, bv);
    finish_and_check(tag, op, av, bv);
  endtask

  initial begin
    rst_n  = 1'b0;
    inp    = 1'b0;
    opcode = 3'd0;
    a      = '0;
    b      = '0;
    repeat (2) @(negedge clk);
    chk("reset.y", 32'(y), 32'd0);
    chk("reset.y_ext", 32'(y_ext), 32'd0);
    chk("reset.ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed test plan values.
    run_op("add_5_13", 3'd0, 8'd5, 8'd13);
    chk("add_5_13.const", 32'(y), 32'd18);
    run_op("sub_5_13", 3'd1, 8'd5, 8'd13);
    chk("sub_5_13.const", 32'({ovf, y}), 32'h1F8);
    run_op("and", 3'd2, 8'd5, 8'd13);
    run_op("or", 3'd3, 8'd5, 8'd13);
    run_op("not", 3'd4, 8'd5, 8'd13);
    chk("not.const", 32'(y), 32'd250);
    run_op("mul_5_13", 3'd7, 8'd5, 8'd13);
    chk("mul_5_13.const", 32'({y_ext, y}), 32'd65);
    run_op("mul_255", 3'd7, 8'd255, 8'd255);
    chk("mul_255.const", 32'({y_ext, y}), 32'hFE01);
    run_op("add_200_100", 3'd0, 8'd200, 8'd100);
    chk("add_200_100.const", 32'({ovf, y}), 32'h12C);
    run_op("sub_13_5", 3'd1, 8'd13, 8'd5);
    run_op("sub_7_7", 3'd1, 8'd7, 8'd7);

    // Shift progressions: y = a << j or a >> j after j edges, counting the start edge.
    start(3'd5, 8'd5, 8'd0);
    for (int j = 1; j <= 4; j++) begin
      chk($sformatf("shl_edge%0d", j), 32'(y), 32'((5 << j) & 8'hFF));
      if (j < 4) @(negedge clk);
    end
    finish_and_check("shl_final", 3'd5, 8'd5, 8'd0);
    start(3'd6, 8'd5, 8'd0);
    for (int j = 1; j <= 4; j++) begin
      chk($sformatf("shr_edge%0d", j), 32'(y), 32'(5 >> j));
      if (j < 4) @(negedge clk);
    end
    finish_and_check("shr_final", 3'd6, 8'd5, 8'd0);

    // Results hold while IDLE.
    run_op("hold", 3'd0, 8'd77, 8'd99);
    repeat (5) @(negedge clk);
    chk("hold.y", 32'(y), 32'd176);

    // Asynchronous reset in the middle of a MUL.
    start(3'd7, 8'd255, 8'd255);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mulrst.y", 32'(y), 32'd0);
    chk("mulrst.y_ext", 32'(y_ext), 32'd0);
    chk("mulrst.ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (N + 2) @(negedge clk);
    chk("mulrst.idle", 32'({y_ext, y, ovf}), 32'd0);

    // A restart during ADD discards the first operation.
    start(3'd0, 8'd200, 8'd100);
    repeat (3) @(negedge clk);
    run_op("restart", 3'd0, 8'd21, 8'd34);

    // Randomised operations.
    for (int i = 0; i < 40; i++) begin
      logic [2:0]   rop;
      logic [N-1:0] ra, rb;
      rop = 3'($urandom);
      ra  = N'($urandom);
      rb  = N'($urandom);
      if (i % 8 == 0) ra = '1;
      if (i % 8 == 1) rb = '1;
      if (i % 8 == 2) rb = ra;
      run_op($sformatf("rnd%0d_op%0d", i, rop), rop, ra, rb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
